// File: rtl/uart_reg_bridge_pkg.sv
// Shared UART protocol constants, FSM state encoding and helpers for uart_reg_bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: opcode/reply bytes, timeout counter width, state and opcode enums, error-count helper.
package uart_reg_bridge_pkg;

  // Host command opcodes and bridge reply bytes.
  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK   = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR  = 8'h3F;  // '?'

  // Inter-byte timeout counter width; TIMEOUT_CYCLES may go up to 2^24-1.
  localparam int unsigned TMO_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_READ,
    ST_RESP
  } state_e;

  typedef enum logic {
    OPC_WR,
    OPC_RD
  } opc_e;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_WRITE) || (b == OP_READ);
  endfunction

  // Saturating increment for the protocol error counter.
  function automatic logic [7:0] err_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/uart_reg_bridge_if.sv
// Bundle of the UART byte stream and the register access bus seen by uart_reg_bridge.
// Latency: n/a (wires only).
// Backpressure: tx_busy stalls the reply byte; rx side has no backpressure.
// Ports: slave = bridge side (consumes rx/tx_busy/reg_rdata, drives wr_*/reg_*),
//        master = environment side (UART core plus register file).
interface uart_reg_bridge_if;

  logic       rx_valid;   // one-cycle pulse: rx_data holds a received byte
  logic [7:0] rx_data;
  logic       tx_busy;    // UART transmitter busy
  logic       wr_en;      // one-cycle pulse: launch wr_data on the transmitter
  logic [7:0] wr_data;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;     // one-cycle write strobe
  logic       reg_re;     // one-cycle read strobe
  logic [7:0] reg_rdata;  // valid the cycle after reg_re

  modport slave (
    input  rx_valid, rx_data, tx_busy, reg_rdata,
    output wr_en, wr_data, reg_addr, reg_wdata, reg_we, reg_re
  );

  modport master (
    output rx_valid, rx_data, tx_busy, reg_rdata,
    input  wr_en, wr_data, reg_addr, reg_wdata, reg_we, reg_re
  );

endinterface

// File: rtl/uart_reg_bridge_timeout.sv
// uart_timeout: counts idle cycles while enabled and flags an inter-byte timeout.
// Latency: expire_o is combinational from the count register, high in the cycle the count hits TIMEOUT_CYCLES-1.
// Backpressure: none; clear_i restarts the count and suppresses expiry in the same cycle.
// Ports: clk, rstb (async active-low), clear_i, enable_i, expire_o.
module uart_timeout
  import uart_reg_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rstb,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  // Count is held at zero outside the waiting states so every wait starts fresh.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !enable_i) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A byte in the expiry cycle (clear_i) wins over the timeout.
  assign expire_o = enable_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: UART responder decoding 'W' addr data / 'R' addr commands into register accesses, one reply byte each.
// Latency: write data byte -> reg_we 1 cycle, -> wr_en 2 cycles; read addr byte -> reg_re 1 cycle, -> wr_en 3 cycles (tx idle).
// Backpressure: reply held in RESP while tx_busy is high; bytes arriving in READ/RESP are dropped and counted as errors.
// Ports: clk, rstb (async active-low), bus (uart_reg_bridge_if.slave), err_cnt (saturating error count), busy (state != IDLE).
module uart_reg_bridge
  import uart_reg_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic                   clk,
  input  logic                   rstb,
  uart_reg_bridge_if.slave       bus,
  output logic [7:0]             err_cnt,
  output logic                   busy
);

  state_e     state_q;
  opc_e       opc_q;
  logic [7:0] reply_q;
  logic       rd_pend_q;   // reply must be taken from reg_rdata this cycle
  logic       wr_en_q;
  logic [7:0] wr_data_q;
  logic [7:0] reg_addr_q;
  logic [7:0] reg_wdata_q;
  logic       reg_we_q;
  logic       reg_re_q;
  logic [7:0] err_cnt_q;

  logic tmo_en;
  logic tmo_expire;

  assign tmo_en = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);

  uart_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rstb     (rstb),
    .clear_i  (bus.rx_valid),
    .enable_i (tmo_en),
    .expire_o (tmo_expire)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      opc_q       <= OPC_WR;
      reply_q     <= 8'h00;
      rd_pend_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= 8'h00;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      err_cnt_q   <= 8'h00;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      wr_en_q  <= 1'b0;
      reg_we_q <= 1'b0;
      reg_re_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (bus.rx_valid) begin
            if (is_opcode(bus.rx_data)) begin
              opc_q   <= (bus.rx_data == OP_READ) ? OPC_RD : OPC_WR;
              state_q <= ST_GET_ADDR;
            end else begin
              reply_q   <= RSP_ERR;
              err_cnt_q <= err_inc(err_cnt_q);
              state_q   <= ST_RESP;
            end
          end
        end

        ST_GET_ADDR: begin
          if (bus.rx_valid) begin
            reg_addr_q <= bus.rx_data;
            if (opc_q == OPC_WR) begin
              state_q <= ST_GET_DATA;
            end else begin
              // reg_re is registered so it is high for the single READ cycle.
              reg_re_q <= 1'b1;
              state_q  <= ST_READ;
            end
          end else if (tmo_expire) begin
            err_cnt_q <= err_inc(err_cnt_q);
            state_q   <= ST_IDLE;
          end
        end

        ST_GET_DATA: begin
          if (bus.rx_valid) begin
            reg_wdata_q <= bus.rx_data;
            reg_we_q    <= 1'b1;
            reply_q     <= RSP_OK;
            state_q     <= ST_RESP;
          end else if (tmo_expire) begin
            err_cnt_q <= err_inc(err_cnt_q);
            state_q   <= ST_IDLE;
          end
        end

        ST_READ: begin
          // reg_rdata arrives next cycle, which is the first RESP cycle.
          if (bus.rx_valid) begin
            err_cnt_q <= err_inc(err_cnt_q);
          end
          rd_pend_q <= 1'b1;
          state_q   <= ST_RESP;
        end

        ST_RESP: begin
          if (bus.rx_valid) begin
            err_cnt_q <= err_inc(err_cnt_q);
          end
          // reg_rdata is only guaranteed for one cycle: latch it even if the
          // transmitter is busy so the reply survives an arbitrary stall.
          if (rd_pend_q) begin
            reply_q   <= bus.reg_rdata;
            rd_pend_q <= 1'b0;
          end
          if (!bus.tx_busy) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= rd_pend_q ? bus.reg_rdata : reply_q;
            state_q   <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.reg_re    = reg_re_q;
  assign err_cnt       = err_cnt_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Testbench for uart_reg_bridge: random and directed host commands against a queue-based scoreboard.
// Latency: expected pulse cycles are derived from the command byte timing.
// Backpressure: transmitter model raises tx_busy for a few cycles after each reply; one test stalls it for 100 cycles.
module tb_uart_reg_bridge;
  import uart_reg_bridge_pkg::*;

  localparam int unsigned TC = 40;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         cyc;   // expected observation cycle, -1 = not checked
  } exp_t;

  logic       clk  = 1'b0;
  logic       rstb = 1'b0;
  logic [7:0] err_cnt;
  logic       busy;

  uart_reg_bridge_if bus();

  uart_reg_bridge #(
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk     (clk),
    .rstb    (rstb),
    .bus     (bus.slave),
    .err_cnt (err_cnt),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  exp_t q_we[$];
  exp_t q_re[$];
  exp_t q_tx[$];

  logic [7:0] model_mem [256];
  logic [7:0] rf_mem    [256];
  int         model_err = 0;

  logic       tx_force      = 1'b0;
  logic       tx_model_busy = 1'b0;
  int         tx_cnt        = 0;
  logic       re_pend       = 1'b0;
  logic [7:0] re_addr       = 8'h00;

  assign bus.tx_busy = tx_force | tx_model_busy;

  // Register file and transmitter responders.
  initial begin
    bus.reg_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (re_pend) bus.reg_rdata = rf_mem[re_addr];
      else         bus.reg_rdata = 8'($urandom);
      re_pend = bus.reg_re;
      re_addr = bus.reg_addr;
      if (bus.reg_we) rf_mem[bus.reg_addr] = bus.reg_wdata;
      tx_model_busy = (tx_cnt > 0);
      if (tx_cnt > 0) tx_cnt--;
      if (bus.wr_en) tx_cnt = $urandom_range(4, 1);
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rstb) begin
      if (bus.reg_we) begin
        checks++;
        if (bus.reg_re) begin
          errors++;
          $display("FAIL we_re_overlap: reg_we and reg_re both 1 at cycle %0d, required not both", cyc);
        end
        if (q_we.size() == 0) begin
          errors++;
          $display("FAIL unexpected_reg_we: addr %h data %h at cycle %0d, required no write", bus.reg_addr, bus.reg_wdata, cyc);
        end else begin
          e = q_we.pop_front();
          checks++;
          if (bus.reg_addr !== e.a || bus.reg_wdata !== e.d || (e.cyc >= 0 && cyc != e.cyc)) begin
            errors++;
            $display("FAIL reg_write: got addr %h data %h cycle %0d, required addr %h data %h cycle %0d",
                     bus.reg_addr, bus.reg_wdata, cyc, e.a, e.d, e.cyc);
          end
        end
      end
      if (bus.reg_re) begin
        checks++;
        if (q_re.size() == 0) begin
          errors++;
          $display("FAIL unexpected_reg_re: addr %h at cycle %0d, required no read", bus.reg_addr, cyc);
        end else begin
          e = q_re.pop_front();
          if (bus.reg_addr !== e.a || (e.cyc >= 0 && cyc != e.cyc)) begin
            errors++;
            $display("FAIL reg_read: got addr %h cycle %0d, required addr %h cycle %0d", bus.reg_addr, cyc, e.a, e.cyc);
          end
        end
      end
      if (bus.wr_en) begin
        checks++;
        if (bus.tx_busy) begin
          errors++;
          $display("FAIL wr_en_while_busy: wr_en with tx_busy=1 at cycle %0d, required tx_busy 0", cyc);
        end
        if (q_tx.size() == 0) begin
          errors++;
          $display("FAIL unexpected_reply: wr_data %h at cycle %0d, required no reply", bus.wr_data, cyc);
        end else begin
          e = q_tx.pop_front();
          checks++;
          if (bus.wr_data !== e.d || (e.cyc >= 0 && cyc != e.cyc)) begin
            errors++;
            $display("FAIL reply: got wr_data %h cycle %0d, required %h cycle %0d", bus.wr_data, cyc, e.d, e.cyc);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  function automatic void model_err_inc();
    if (model_err < 255) model_err++;
  endfunction

  // Byte is on the bus for cycle k (returned), sampled by the DUT at the end of it.
  task automatic send_byte(input logic [7:0] b, output int k);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    k = cyc;
    tick(1);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int gap);
    int k;
    send_byte(OP_WRITE, k);
    tick(gap);
    send_byte(a, k);
    tick(gap);
    send_byte(d, k);
    model_mem[a] = d;
    q_we.push_back('{a, d, k + 1});
    q_tx.push_back('{8'h00, RSP_OK, k + 2});
  endtask

  task automatic do_read(input logic [7:0] a, input int gap);
    int k;
    send_byte(OP_READ, k);
    tick(gap);
    send_byte(a, k);
    q_re.push_back('{a, 8'h00, k + 1});
    q_tx.push_back('{8'h00, model_mem[a], k + 3});
  endtask

  task automatic do_illegal(input logic [7:0] b);
    int k;
    send_byte(b, k);
    model_err_inc();
    q_tx.push_back('{8'h00, RSP_ERR, k + 2});
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((q_we.size() + q_re.size() + q_tx.size() != 0 || busy || bus.tx_busy) && n < 1000) begin
      tick(1);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL %s: no idle within 1000 cycles, pending we/re/tx %0d/%0d/%0d, required 0/0/0",
               name, q_we.size(), q_re.size(), q_tx.size());
    end
  endtask

  task automatic check_all_zero(input string tag);
    check8({tag, "_wr_en"},     8'(bus.wr_en),  8'h00);
    check8({tag, "_wr_data"},   bus.wr_data,    8'h00);
    check8({tag, "_reg_addr"},  bus.reg_addr,   8'h00);
    check8({tag, "_reg_wdata"}, bus.reg_wdata,  8'h00);
    check8({tag, "_reg_we"},    8'(bus.reg_we), 8'h00);
    check8({tag, "_reg_re"},    8'(bus.reg_re), 8'h00);
    check8({tag, "_err_cnt"},   err_cnt,        8'h00);
    check8({tag, "_busy"},      8'(busy),       8'h00);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k;
    int t;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] b;
    exp_t e;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom);
      model_mem[i] = d;
      rf_mem[i]    = d;
    end

    // Reset state.
    tick(3);
    check_all_zero("reset");
    rstb = 1'b1;
    tick(2);

    // Basic write and read vectors.
    do_write(8'h10, 8'hA5, 0);
    wait_idle("write_10");
    check8("rf_after_write", rf_mem[8'h10], 8'hA5);
    model_mem[8'h22] = 8'h5C;
    rf_mem[8'h22]    = 8'h5C;
    do_read(8'h22, 1);
    wait_idle("read_22");

    // Illegal byte, then a write that times out waiting for data.
    do_illegal(8'h00);
    wait_idle("illegal_00");
    check8("err_after_illegal", err_cnt, 8'(model_err));
    send_byte(OP_WRITE, k);
    send_byte(8'h01, k);
    tick(TC - 1);
    check8("busy_at_expiry_data", 8'(busy), 8'h01);
    tick(1);
    model_err_inc();
    check8("busy_after_expiry_data", 8'(busy), 8'h00);
    check8("err_after_timeout", err_cnt, 8'(model_err));
    tick(10);

    // Timeout while waiting for the address byte.
    send_byte(OP_READ, k);
    tick(TC - 1);
    check8("busy_at_expiry_addr", 8'(busy), 8'h01);
    tick(1);
    model_err_inc();
    check8("busy_after_expiry_addr", 8'(busy), 8'h00);
    check8("err_after_addr_timeout", err_cnt, 8'(model_err));
    tick(5);

    // Data byte landing exactly in the expiry cycle is accepted.
    send_byte(OP_WRITE, k);
    send_byte(8'h44, k);
    tick(TC - 1);
    send_byte(8'h99, k);
    model_mem[8'h44] = 8'h99;
    q_we.push_back('{8'h44, 8'h99, k + 1});
    q_tx.push_back('{8'h00, RSP_OK, k + 2});
    wait_idle("expiry_race");
    check8("err_after_race", err_cnt, 8'(model_err));

    // Transmitter stalled for 100 cycles during a read reply; extra byte in RESP is dropped.
    tx_force = 1'b1;
    send_byte(OP_READ, k);
    send_byte(8'h44, k);
    q_re.push_back('{8'h44, 8'h00, k + 1});
    q_tx.push_back('{8'h00, model_mem[8'h44], -1});
    tick(10);
    send_byte(OP_WRITE, k);
    model_err_inc();
    tick(88);
    check8("reply_held_while_busy", 8'(q_tx.size()), 8'h01);
    e = q_tx.pop_front();
    e.cyc = cyc + 1;
    q_tx.push_front(e);
    tx_force = 1'b0;
    wait_idle("busy_stall");
    check8("err_after_resp_byte", err_cnt, 8'(model_err));

    // Randomized command mix.
    for (int i = 0; i < 60; i++) begin
      t = $urandom_range(2, 0);
      a = 8'($urandom_range(15, 0));
      d = 8'($urandom);
      if (t == 0) begin
        do_write(a, d, $urandom_range(5, 0));
      end else if (t == 1) begin
        do_read(a, $urandom_range(5, 0));
      end else begin
        b = 8'($urandom);
        while (b == OP_WRITE || b == OP_READ) b = 8'($urandom);
        do_illegal(b);
      end
      wait_idle("random");
    end
    check8("err_after_random", err_cnt, 8'(model_err));

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      do_illegal(8'hE0);
      wait_idle("saturate");
    end
    check8("err_saturated", err_cnt, 8'hFF);

    // Reset in the middle of a write command.
    send_byte(OP_WRITE, k);
    send_byte(8'h33, k);
    rstb = 1'b0;
    #1;
    check_all_zero("midreset");
    tick(2);
    rstb = 1'b1;
    model_err = 0;
    tick(20);
    do_write(8'h33, 8'h77, 1);
    wait_idle("post_reset_write");
    check8("err_after_reset_cmd", err_cnt, 8'h00);
    do_read(8'h33, 0);
    wait_idle("post_reset_read");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_reg_bridge.md
UART_REG_BRIDGE -- requirements
Module: uart_reg_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 5000000, the inter-byte timeout in clk cycles (0.1 s at 50 MHz); legal range 2..2^24-1.
REQ-002 SHALL have ports: clk  in  1  system clock, 50 MHz; all logic on the rising edge.
REQ-003 SHALL have ports: rstb  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports: rx_valid  in  1  one-cycle pulse, a received UART byte is on rx_data.
REQ-005 SHALL have ports: rx_data  in  8  received byte.
REQ-006 SHALL have ports: tx_busy  in  1  UART transmitter busy.
REQ-007 SHALL have ports: wr_en  out  1  one-cycle pulse, launch wr_data on the UART transmitter.
REQ-008 SHALL have ports: wr_data  out  8  reply byte.
REQ-009 SHALL have ports: reg_addr  out  8, reg_wdata  out  8, reg_we  out  1 (one-cycle pulse), reg_re  out  1 (one-cycle pulse), reg_rdata  in  8 (valid the cycle after reg_re).
REQ-010 SHALL have ports: err_cnt  out  8  saturating protocol-error count; busy  out  1  high whenever the state is not IDLE.

Function
REQ-011 SHALL be the responder end of the UART link: it decodes host command bytes into register accesses and returns one reply byte per command.
REQ-012 SHALL implement the FSM states IDLE, GET_ADDR, GET_DATA, READ, RESP.
REQ-013 In IDLE, on rx_valid:
- 0x57 ('W') or 0x52 ('R') SHALL latch the opcode and go to GET_ADDR.
- Any other byte SHALL load reply 0x3F ('?'), increment err_cnt, and go to RESP.
REQ-014 In GET_ADDR, rx_valid SHALL latch reg_addr. Opcode 'W' then goes to GET_DATA; opcode 'R' goes to READ.
REQ-015 In GET_DATA, rx_valid SHALL drive reg_wdata=rx_data and pulse reg_we for exactly one cycle, in the cycle after the byte arrives; reply is 0x4B ('K'); next state is RESP.
REQ-016 On entry to READ, reg_re SHALL pulse for one cycle. reg_rdata SHALL be captured into the reply on the following cycle. Next state is RESP.
REQ-017 In RESP, wr_en SHALL pulse for one cycle with wr_data=reply in the first cycle tx_busy is low; the FSM then returns to IDLE.
REQ-018 While tx_busy is high, RESP SHALL hold and wr_en SHALL stay low; no reply byte is dropped or duplicated.
REQ-019 An rx_valid pulse in READ or RESP SHALL be discarded and SHALL increment err_cnt.
REQ-020 Inter-byte timeout:
- In GET_ADDR and GET_DATA, a counter SHALL count cycles since the last rx_valid.
- On reaching TIMEOUT_CYCLES-1 with no byte, the FSM SHALL return to IDLE with no register access and no reply, and err_cnt SHALL increment.
REQ-021 A byte arriving in the same cycle as the timeout expiry SHALL win: the byte is accepted and no error is counted.
REQ-022 err_cnt SHALL saturate at 0xFF and never wrap; it is cleared only by reset.
REQ-023 Latency SHALL be: write command, last byte's rx_valid to reg_we = 1 cycle and to wr_en = 2 cycles (tx idle); read command, addr byte's rx_valid to reg_re = 1 cycle and to wr_en = 3 cycles (tx idle).
REQ-024 reg_we and reg_re SHALL never be high in the same cycle, and wr_en SHALL never be high while tx_busy is high.

Reset
REQ-025 On rstb low, the state SHALL go to IDLE immediately, and wr_en, wr_data, reg_addr, reg_wdata, reg_we, reg_re, err_cnt, busy and the timeout counter SHALL all be 0.
REQ-026 Reset in mid-command SHALL abort the command; no reg_we, reg_re or wr_en pulse occurs after rstb is released until a new command completes.

Structure
REQ-027 Opcode and reply constants (0x57, 0x52, 0x4B, 0x3F) SHALL live in the shared UART defines include, used by both this block and the test bench.
REQ-028 The timeout counter SHALL be the one sub-module, uart_timeout, with inputs clear and enable, parameter TIMEOUT_CYCLES, and a one-cycle expire pulse output.
REQ-029 The block SHALL connect directly to uart_top's rx_valid/rx_data/tx_busy/wr_en/wr_data ports and need no glue logic.

Verification
REQ-030 Bytes 0x57, 0x10, 0xA5 -> reg_we pulses once with reg_addr=0x10 and reg_wdata=0xA5; then wr_en pulses once with wr_data=0x4B.
REQ-031 Bytes 0x52, 0x22 with reg_rdata=0x5C -> reg_re pulses once with reg_addr=0x22; then wr_data=0x5C on wr_en.
REQ-032 Byte 0x00 -> wr_data=0x3F and err_cnt=1. Then 0x57, 0x01 followed by silence for TIMEOUT_CYCLES -> back to IDLE, no reg_we, no reply, err_cnt=2.
REQ-033 tx_busy held high for 100 cycles during RESP -> wr_en stays low and pulses exactly once on the first low cycle.
REQ-034 300 illegal bytes -> err_cnt=0xFF, no wrap. rstb pulsed while in GET_DATA -> all outputs 0; next valid 'W' command completes normally.
